cpu_mc: RTL and testbench

Parametrised multicycle CPU core and successor to the fixed-width 4-state core. Sequences FETCH/DECODE/EXECUTE/WRITE_BACK with a ready-based instruction-memory handshake instead of a free-running state counter. Also adds width and register-count parameters, conditional branches, HALT and a debug register read port. It is the top-level core the testbench instantiates, with instruction memory external.

---
 rtl/cpu_mc_pkg.sv | 31 +++
 rtl/cpu_regfile.sv | 44 ++++
 rtl/cpu_mc.sv | 155 +++++++++++++++
 tb/tb_cpu_mc.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the cpu_mc multicycle core.
// Holds the state encodings visible on state_dbg, the opcode values and a
// helper that says which opcodes update the register file.
package cpu_mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_WRITE_BACK = 3'd3,
    S_HALTED     = 3'd4
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_OR   = 5'd4;
  localparam logic [4:0] OP_MOV  = 5'd5;
  localparam logic [4:0] OP_BR   = 5'd6;
  localparam logic [4:0] OP_BZ   = 5'd7;
  localparam logic [4:0] OP_BNZ  = 5'd8;
  localparam logic [4:0] OP_HALT = 5'd31;

  // Only the ALU/MOV group writes a destination register.
  function automatic logic op_writes_reg(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Architectural register file for cpu_mc.
// Ports:
//   clk, reset    - clock and synchronous active-low reset (clears all registers)
//   we/waddr/wdata- synchronous write port; writes to register 0 are dropped
//   ra_*, rb_*    - two combinational read ports (operands a and b)
//   dbg_addr/data - combinational debug read port
// Register 0 always reads as zero.
module cpu_regfile
  import cpu_mc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
  assign rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/cpu_mc.sv
// cpu_mc: parametrised multicycle CPU core.
// Each instruction walks FETCH -> DECODE -> EXECUTE -> WRITE_BACK; FETCH
// waits for imem_ready, and HALT parks the core in HALTED until reset.
// Ports:
//   clk, reset            - clock, synchronous active-low reset
//   imem_req, imem_addr   - fetch request and word address (the PC)
//   imem_ready, imem_data - fetch handshake and instruction word
//   halted                - set once HALT has been decoded
//   state_dbg             - current state encoding
//   dbg_addr, dbg_data    - combinational debug register read
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_COUNT = 32,
  parameter int PC_WIDTH  = 16,
  localparam int AW       = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_data,
  output logic                halted,
  output logic [2:0]          state_dbg,
  input  logic [AW-1:0]       dbg_addr,
  output logic [WIDTH-1:0]    dbg_data
);

  state_t                    state;
  logic [PC_WIDTH-1:0]       pc;
  logic [31:0]               inst_p0;
  logic signed [WIDTH-1:0]   opa_p1;
  logic signed [WIDTH-1:0]   opb_p1;
  logic signed [WIDTH-1:0]   res_p2;
  logic                      taken_p2;

  // Instruction fields; register indices keep only the low AW bits.
  logic [4:0]              op;
  logic [AW-1:0]           z_idx;
  logic [AW-1:0]           a_idx;
  logic [AW-1:0]           b_idx;
  logic signed [15:0]      imm_s;
  logic signed [WIDTH-1:0] imm_w;
  logic [PC_WIDTH-1:0]     imm_pc;

  assign op     = inst_p0[31:27];
  assign z_idx  = inst_p0[16 +: AW];
  assign a_idx  = inst_p0[5 +: AW];
  assign b_idx  = inst_p0[0 +: AW];
  assign imm_s  = inst_p0[15:0];
  assign imm_w  = WIDTH'(imm_s);
  assign imm_pc = PC_WIDTH'(imm_s);

  // Bits such as inst[26:21] carry no meaning for this core.
  logic unused_inst_bits;
  assign unused_inst_bits = ^inst_p0;

  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             rf_we;

  assign rf_we = (state == S_WRITE_BACK) && op_writes_reg(op);

  cpu_regfile #(
    .WIDTH     (WIDTH),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (z_idx),
    .wdata    (res_p2),
    .ra_addr  (a_idx),
    .ra_data  (ra_data),
    .rb_addr  (b_idx),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // ALU and branch condition, consumed at the end of EXECUTE.
  logic signed [WIDTH-1:0] alu_res;
  logic                    br_take;

  always_comb begin
    alu_res = '0;
    br_take = 1'b0;
    case (op)
      OP_ADD:  alu_res = opa_p1 + opb_p1;
      OP_SUB:  alu_res = opa_p1 - opb_p1;
      OP_AND:  alu_res = opa_p1 & opb_p1;
      OP_OR:   alu_res = opa_p1 | opb_p1;
      OP_MOV:  alu_res = imm_w;
      OP_BR:   br_take = 1'b1;
      OP_BZ:   br_take = (opa_p1 == '0);
      OP_BNZ:  br_take = (opa_p1 != '0);
      OP_NOP:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= '0;
      inst_p0  <= '0;
      opa_p1   <= '0;
      opb_p1   <= '0;
      res_p2   <= '0;
      taken_p2 <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        // ---- FETCH: hold the PC until memory answers ----
        S_FETCH: begin
          if (imem_ready) begin
            inst_p0 <= imem_data;
            state   <= S_DECODE;
          end
        end
        // ---- DECODE: operand read or halt ----
        S_DECODE: begin
          if (op == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else begin
            opa_p1 <= ra_data;
            opb_p1 <= rb_data;
            state  <= S_EXECUTE;
          end
        end
        // ---- EXECUTE: register result and branch decision ----
        S_EXECUTE: begin
          res_p2   <= alu_res;
          taken_p2 <= br_take;
          state    <= S_WRITE_BACK;
        end
        // ---- WRITE_BACK: PC update lands with the register write ----
        S_WRITE_BACK: begin
          pc    <= taken_p2 ? (pc + imm_pc) : (pc + PC_WIDTH'(1));
          state <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_FETCH;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_mc.sv
module tb_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=32, REG_COUNT=32, PC_WIDTH=16
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        halted;
  logic [2:0]  state_dbg;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  cpu_mc #(.WIDTH(32), .REG_COUNT(32), .PC_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data), .halted(halted),
    .state_dbg(state_dbg), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Narrow instance: WIDTH=16, REG_COUNT=8
  logic        reset2;
  logic        req2;
  logic [15:0] addr2;
  logic [31:0] data2;
  logic        halted2;
  logic [2:0]  st2;
  logic [2:0]  dbg_addr2;
  logic [15:0] dbg_data2;
  logic [31:0] mem2 [256];

  assign data2 = mem2[addr2[7:0]];

  cpu_mc #(.WIDTH(16), .REG_COUNT(8), .PC_WIDTH(16)) dut2 (
    .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(1'b1), .imem_data(data2), .halted(halted2),
    .state_dbg(st2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem1 [256];

  // Architectural reference: register values, PC and halt flag.
  logic [31:0] rr [32];
  logic [15:0] rpc;
  bit          rhalt;

  function automatic logic [31:0] enc_r(input int op, input int z, input int a, input int b);
    logic [31:0] w;
    w = '0;
    w[31:27] = op[4:0];
    w[20:16] = z[4:0];
    w[10:5]  = a[5:0];
    w[4:0]   = b[4:0];
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int z, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[31:27] = op[4:0];
    w[20:16] = z[4:0];
    w[15:0]  = imm;
    return w;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) rr[i] = '0;
    rpc   = '0;
    rhalt = 0;
  endtask

  // Executes one non-HALT instruction on the reference state.
  task automatic ref_step(input logic [31:0] ins);
    int op, z, a, b, ofs;
    logic [31:0] va, vb, val;
    bit wr, take;
    op  = int'(ins[31:27]);
    z   = int'(ins[20:16]);
    a   = int'(ins[10:5]) % 32;
    b   = int'(ins[4:0]);
    va  = rr[a];
    vb  = rr[b];
    ofs = int'($signed(ins[15:0]));
    wr  = 0;
    take = 0;
    val = '0;
    case (op)
      1: begin val = va + vb; wr = 1; end
      2: begin val = va - vb; wr = 1; end
      3: begin val = va & vb; wr = 1; end
      4: begin val = va | vb; wr = 1; end
      5: begin val = 32'(ofs); wr = 1; end
      6: take = 1;
      7: take = (va == 0);
      8: take = (va != 0);
      default: ;
    endcase
    if (wr && z != 0) rr[z] = val;
    if (take) rpc = 16'(int'(rpc) + ofs);
    else      rpc = 16'(int'(rpc) + 1);
  endtask

  task automatic clear_mem(input logic [31:0] fill);
    for (int i = 0; i < 256; i++) mem1[i] = fill;
  endtask

  // Reset for two cycles, check reset values, release on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ready = 1'b0;
    imem_data = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd0 || imem_req !== 1'b1 || imem_addr !== 16'd0 || halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: state=%0d req=%b addr=%h halted=%b, required 0/1/0000/0",
               state_dbg, imem_req, imem_addr, halted);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      n_cmp++;
      if (dbg_data !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_reg r%0d: got %h, required 00000000", i, dbg_data);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    ref_reset();
  endtask

  // Runs one instruction from a falling edge in FETCH with w wait cycles.
  task automatic do_instr(input int w, output int cyc);
    logic [31:0] ins;
    int z;
    ins = mem1[rpc[7:0]];
    z   = int'(ins[20:16]);
    cyc = 0;
    n_cmp++;
    if (state_dbg !== 3'd0 || imem_req !== 1'b1 || imem_addr !== rpc) begin
      n_bad++;
      $display("FAIL fetch_entry: state=%0d req=%b addr=%h, required 0/1/%h",
               state_dbg, imem_req, imem_addr, rpc);
    end
    for (int i = 0; i < w; i++) begin
      imem_ready = 1'b0;
      imem_data  = $urandom;
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (state_dbg !== 3'd0 || imem_req !== 1'b1 || imem_addr !== rpc) begin
        n_bad++;
        $display("FAIL fetch_wait: state=%0d req=%b addr=%h, required 0/1/%h",
                 state_dbg, imem_req, imem_addr, rpc);
      end
    end
    imem_ready = 1'b1;
    imem_data  = ins;
    @(negedge clk);
    cyc++;
    imem_ready = 1'($urandom_range(0, 1));
    imem_data  = $urandom;
    n_cmp++;
    if (state_dbg !== 3'd1) begin
      n_bad++;
      $display("FAIL decode_state: got %0d, required 1", state_dbg);
    end
    if (ins[31:27] == 5'd31) begin
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if (halted !== 1'b1 || state_dbg !== 3'd4 || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL halt_entry: halted=%b state=%0d req=%b, required 1/4/0",
                 halted, state_dbg, imem_req);
      end
      rhalt = 1;
      return;
    end
    @(negedge clk);
    cyc++;
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_bad++;
      $display("FAIL execute_state: got %0d, required 2", state_dbg);
    end
    @(negedge clk);
    cyc++;
    n_cmp++;
    if (state_dbg !== 3'd3) begin
      n_bad++;
      $display("FAIL wb_state: got %0d, required 3", state_dbg);
    end
    // During WRITE_BACK the destination still shows its previous value.
    dbg_addr = 5'(z);
    #1;
    n_cmp++;
    if (dbg_data !== rr[z]) begin
      n_bad++;
      $display("FAIL wb_old_value r%0d: got %h, required %h", z, dbg_data, rr[z]);
    end
    @(negedge clk);
    cyc++;
    imem_ready = 1'b0;
    ref_step(ins);
    n_cmp++;
    if (cyc != w + 4) begin
      n_bad++;
      $display("FAIL instr_cycles: got %0d, required %0d", cyc, w + 4);
    end
    n_cmp++;
    if (state_dbg !== 3'd0 || imem_addr !== rpc) begin
      n_bad++;
      $display("FAIL next_fetch: state=%0d addr=%h, required 0/%h", state_dbg, imem_addr, rpc);
    end
    #1;
    n_cmp++;
    if (dbg_data !== rr[z]) begin
      n_bad++;
      $display("FAIL wb_new_value r%0d: got %h, required %h", z, dbg_data, rr[z]);
    end
  endtask

  task automatic run_prog(input int max_n, input int wmax);
    int c;
    for (int n = 0; n < max_n && !rhalt; n++) do_instr($urandom_range(0, wmax), c);
    n_cmp++;
    if (!rhalt) begin
      n_bad++;
      $display("FAIL run_bound: no HALT within %0d instructions, required halted=1", max_n);
    end
  endtask

  task automatic check_reg(input string nm, input int r, input logic [31:0] exp);
    dbg_addr = 5'(r);
    #1;
    n_cmp++;
    if (dbg_data !== exp) begin
      n_bad++;
      $display("FAIL %s r%0d: got %h, required %h", nm, r, dbg_data, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  // MOV r1,#5; MOV r2,#-3; HALT with imem_ready tied high.
  task automatic test_mov();
    int k;
    clear_mem(32'd0);
    mem1[0] = enc_i(5, 1, 16'd5);
    mem1[1] = enc_i(5, 2, 16'hFFFD);
    mem1[2] = enc_i(31, 0, 16'd0);
    apply_reset();
    imem_ready = 1'b1;
    imem_data  = mem1[imem_addr[7:0]];
    // k counts rising edges with reset high, starting at 0.
    for (k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      imem_data = mem1[imem_addr[7:0]];
      if (halted === 1'b1) break;
    end
    imem_ready = 1'b0;
    n_cmp++;
    if (k != 9) begin
      n_bad++;
      $display("FAIL halt_cycle: halted rose at cycle %0d, required 9", k);
    end
    @(negedge clk);
    check_reg("mov_pos", 1, 32'd5);
    check_reg("mov_neg", 2, 32'hFFFFFFFD);
  endtask

  task automatic test_arith();
    clear_mem(32'd0);
    mem1[0] = enc_i(5, 1, 16'd5);
    mem1[1] = enc_i(5, 2, 16'hFFFD);
    mem1[2] = enc_r(1, 3, 1, 2);
    mem1[3] = enc_r(2, 4, 2, 1);
    mem1[4] = enc_r(1, 0, 1, 1);
    mem1[5] = enc_i(31, 0, 16'd0);
    apply_reset();
    run_prog(10, 1);
    check_reg("add", 3, 32'd2);
    check_reg("sub", 4, 32'hFFFFFFF8);
    check_reg("r0_write", 0, 32'd0);
  endtask

  task automatic test_handshake();
    int c;
    clear_mem(32'd0);
    mem1[0] = enc_i(5, 1, 16'd7);
    mem1[1] = enc_i(31, 0, 16'd0);
    apply_reset();
    do_instr(3, c);
    n_cmp++;
    if (c != 7) begin
      n_bad++;
      $display("FAIL handshake_cycles: got %0d, required 7", c);
    end
    do_instr(2, c);
    check_reg("handshake_mov", 1, 32'd7);
  endtask

  task automatic test_branches();
    int c;
    // BZ at PC 4 back to 0
    clear_mem(32'd0);
    mem1[4] = enc_i(7, 0, 16'hFFFC);
    apply_reset();
    for (int i = 0; i < 5; i++) do_instr($urandom_range(0, 1), c);
    n_cmp++;
    if (imem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL bz_target: got %h, required 0000", imem_addr);
    end
    // BNZ on zero falls through to 5
    clear_mem(32'd0);
    mem1[4] = enc_i(8, 0, 16'd10);
    apply_reset();
    for (int i = 0; i < 5; i++) do_instr($urandom_range(0, 1), c);
    n_cmp++;
    if (imem_addr !== 16'h0005) begin
      n_bad++;
      $display("FAIL bnz_fallthrough: got %h, required 0005", imem_addr);
    end
    // BR -1 from 0 wraps to FFFF
    clear_mem(32'd0);
    mem1[0]   = enc_i(6, 0, 16'hFFFF);
    mem1[255] = enc_i(31, 0, 16'd0);
    apply_reset();
    do_instr(0, c);
    n_cmp++;
    if (imem_addr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL br_wrap: got %h, required FFFF", imem_addr);
    end
    do_instr(0, c);
  endtask

  task automatic test_reset_mid();
    int c;
    clear_mem(32'd0);
    mem1[0] = enc_i(5, 1, 16'd5);
    mem1[1] = enc_r(1, 5, 1, 1);
    mem1[2] = enc_i(31, 0, 16'd0);
    apply_reset();
    do_instr(0, c);
    imem_ready = 1'b1;
    imem_data  = mem1[1];
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_reset_setup: state=%0d, required 2", state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_dbg !== 3'd0 || imem_addr !== 16'd0 || imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_reset_state: state=%0d addr=%h req=%b, required 0/0000/1",
               state_dbg, imem_addr, imem_req);
    end
    check_reg("mid_reset_r5", 5, 32'd0);
    check_reg("mid_reset_r1", 1, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    ref_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 16'd0) begin
      n_bad++;
      $display("FAIL post_reset_req: req=%b addr=%h, required 1/0000", imem_req, imem_addr);
    end
    @(negedge clk);
    run_prog(10, 2);
    check_reg("rerun_r5", 5, 32'd10);
  endtask

  task automatic test_random(input int len);
    logic [31:0] ins;
    int sel, op;
    logic [15:0] imm;
    clear_mem(enc_i(31, 0, 16'd0));
    for (int i = 0; i < len; i++) begin
      sel = $urandom_range(0, 9);
      ins = $urandom;
      if (sel <= 5) begin
        ins[31:27] = 5'(sel);
      end else if (sel == 6) begin
        op  = 6 + $urandom_range(0, 2);
        imm = 16'(($urandom_range(0, 1) << 5) | $urandom_range(1, 3));
        ins = enc_i(op, $urandom_range(0, 31), imm);
      end else if (sel == 7) begin
        ins[31:27] = 5'($urandom_range(9, 30));
      end else begin
        ins[31:27] = 5'd5;
      end
      mem1[i] = ins;
    end
    apply_reset();
    run_prog(4 * len, 3);
    for (int r = 0; r < 32; r++) check_reg("random_reg", r, rr[r]);
    imem_ready = 1'b1;
    repeat (5) @(negedge clk);
    imem_ready = 1'b0;
    n_cmp++;
    if (halted !== 1'b1 || state_dbg !== 3'd4 || imem_req !== 1'b0 || imem_addr !== rpc) begin
      n_bad++;
      $display("FAIL halt_hold: halted=%b state=%0d req=%b addr=%h, required 1/4/0/%h",
               halted, state_dbg, imem_req, imem_addr, rpc);
    end
  endtask

  task automatic test_param();
    int k;
    for (int i = 0; i < 256; i++) mem2[i] = enc_i(31, 0, 16'd0);
    mem2[0] = enc_i(5, 9, 16'h7FFF);
    mem2[1] = enc_i(5, 2, 16'd1);
    mem2[2] = enc_r(1, 3, 9, 10);
    mem2[3] = enc_i(5, 4, 16'hFFFE);
    mem2[4] = enc_i(31, 0, 16'd0);
    @(negedge clk);
    reset2 = 1'b0;
    repeat (2) @(negedge clk);
    reset2 = 1'b1;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (halted2 === 1'b1) break;
    end
    n_cmp++;
    if (halted2 !== 1'b1) begin
      n_bad++;
      $display("FAIL param_halt: halted=%b, required 1", halted2);
    end
    dbg_addr2 = 3'd1;
    #1;
    n_cmp++;
    if (dbg_data2 !== 16'h7FFF) begin
      n_bad++;
      $display("FAIL param_alias r1: got %h, required 7fff", dbg_data2);
    end
    dbg_addr2 = 3'd3;
    #1;
    n_cmp++;
    if (dbg_data2 !== 16'h8000) begin
      n_bad++;
      $display("FAIL param_add r3: got %h, required 8000", dbg_data2);
    end
    dbg_addr2 = 3'd4;
    #1;
    n_cmp++;
    if (dbg_data2 !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL param_sext r4: got %h, required fffe", dbg_data2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    reset2     = 1'b0;
    imem_ready = 1'b0;
    imem_data  = '0;
    dbg_addr   = '0;
    dbg_addr2  = '0;
    ref_reset();
    test_reset();
    test_mov();
    test_arith();
    test_handshake();
    test_branches();
    test_reset_mid();
    test_random(48);
    test_random(64);
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
